// File: rtl/iseq_fetcher_pkg.sv
// Shared definitions for the instruction-sequence fetcher: opcode field, END marker
// and the fetch FSM state encodings.
package iseq_fetcher_pkg;

    localparam int OPC_MSB = 31;
    localparam int OPC_LSB = 28;

    // Opcode that terminates a normal Iseq; maintenance Iseqs carry no END word.
    localparam logic [3:0] END_ISEQ = 4'hF;

    localparam logic [1:0] ISEQ_FETCH_IDLE   = 2'd0;
    localparam logic [1:0] ISEQ_FETCH_SETTLE = 2'd1;
    localparam logic [1:0] ISEQ_FETCH_FETCH  = 2'd2;
    localparam logic [1:0] ISEQ_FETCH_DRAIN  = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE   = ISEQ_FETCH_IDLE,
        ST_SETTLE = ISEQ_FETCH_SETTLE,
        ST_FETCH  = ISEQ_FETCH_FETCH,
        ST_DRAIN  = ISEQ_FETCH_DRAIN
    } fetch_state_e;

    function automatic logic is_end_iseq(input logic [31:0] word);
        return word[OPC_MSB:OPC_LSB] == END_ISEQ;
    endfunction

endpackage

// File: rtl/iseq_fetcher_out_reg.sv
// One-entry valid/ready holding register between the FIFO heads and the
// execution pipeline; a load always wins over a same-cycle drain.
module iseq_out_reg (
    input  logic        clk,
    input  logic        rst,
    input  logic        load,
    input  logic [31:0] load_data,
    input  logic        ready,
    output logic        valid,
    output logic [31:0] data
);

    // NOTE: state registers use non-blocking assignments so every flop samples
    // pre-edge values, independent of process evaluation order.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid <= 1'b0;
            // NOTE: the data word is reset too; it is a single register, not a
            // memory, and the downstream side sees a defined zero after reset.
            data  <= '0;
        end else if (load) begin
            valid <= 1'b1;
            data  <= load_data;
        end else if (ready) begin
            valid <= 1'b0;
        end
    end

endmodule

// File: rtl/iseq_fetcher.sv
// Pops one Iseq from the instr0/instr1 FIFOs in alternating write order and streams it
// to the execution pipeline, signalling the receiver when the next Iseq may start.
module iseq_fetcher
    import iseq_fetcher_pkg::*;
#(
    parameter int START_DELAY = 2,
    parameter int CNT_W       = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             process_iseq,
    output logic             dispatcher_ready,
    output logic             instr0_fifo_rd_en,
    input  logic [31:0]      instr0_fifo_data,
    input  logic             instr0_fifo_empty,
    output logic             instr1_fifo_rd_en,
    input  logic [31:0]      instr1_fifo_data,
    input  logic             instr1_fifo_empty,
    output logic             instr_valid,
    input  logic             instr_ready,
    output logic [31:0]      instr_data,
    output logic             iseq_done,
    output logic [CNT_W-1:0] instr_count,
    output logic             order_err
);

    localparam int DLY_W = 8;

    fetch_state_e state, state_nxt;
    logic             sel;
    logic [DLY_W-1:0] dly_cnt;
    logic             pop;
    logic             load;
    logic             set_err;
    logic [31:0]      head;
    logic             sel_empty;
    logic             oth_empty;

    assign head      = sel ? instr1_fifo_data  : instr0_fifo_data;
    assign sel_empty = sel ? instr1_fifo_empty : instr0_fifo_empty;
    assign oth_empty = sel ? instr0_fifo_empty : instr1_fifo_empty;

    assign dispatcher_ready  = (state == ST_IDLE);
    assign instr0_fifo_rd_en = pop & ~sel;
    assign instr1_fifo_rd_en = pop &  sel;

    // NOTE: every signal written here gets a default first, so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        state_nxt = state;
        pop       = 1'b0;
        load      = 1'b0;
        set_err   = 1'b0;
        iseq_done = 1'b0;
        case (state)
            ST_IDLE: begin
                if (process_iseq) state_nxt = ST_SETTLE;
            end
            // Leave once the counter has run down, giving a START_DELAY-cycle
            // gap from the pulse to the first read.
            ST_SETTLE: begin
                if (dly_cnt <= DLY_W'(1)) state_nxt = ST_FETCH;
            end
            ST_FETCH: begin
                if (sel_empty) begin
                    state_nxt = ST_DRAIN;
                    set_err   = ~oth_empty;
                end else if (!instr_valid || instr_ready) begin
                    pop = 1'b1;
                    if (is_end_iseq(head)) state_nxt = ST_DRAIN;
                    else                   load      = 1'b1;
                end
            end
            ST_DRAIN: begin
                if (!instr_valid || instr_ready) begin
                    iseq_done = 1'b1;
                    state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= ST_IDLE;
            sel         <= 1'b0;
            dly_cnt     <= '0;
            instr_count <= '0;
            order_err   <= 1'b0;
        end else begin
            state <= state_nxt;
            if (state == ST_IDLE && process_iseq) begin
                sel         <= 1'b0;
                instr_count <= '0;
                dly_cnt     <= DLY_W'(START_DELAY - 1);
            end
            if (state == ST_SETTLE && dly_cnt != '0) dly_cnt <= dly_cnt - 1'b1;
            if (pop) sel <= ~sel;
            if (load && instr_count != '1) instr_count <= instr_count + 1'b1;
            if (set_err) order_err <= 1'b1;
        end
    end

    iseq_out_reg u_out_reg (
        .clk       (clk),
        .rst       (rst),
        .load      (load),
        .load_data (head),
        .ready     (instr_ready),
        .valid     (instr_valid),
        .data      (instr_data)
    );

endmodule

// File: tb/tb_iseq_fetcher.sv
// Scoreboard bench for iseq_fetcher: behavioural FIFO models, an interleaving reference
// model feeding an expected-output queue, and a monitor comparing accepted words.
module tb_iseq_fetcher;
    import iseq_fetcher_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        process_iseq;
    logic        dispatcher_ready;
    logic        rd0, rd1;
    logic [31:0] d0, d1;
    logic        e0, e1;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instr_data;
    logic        iseq_done;
    logic [15:0] instr_count;
    logic        order_err;

    iseq_fetcher #(.START_DELAY(2), .CNT_W(16)) dut (
        .clk               (clk),
        .rst               (rst),
        .process_iseq      (process_iseq),
        .dispatcher_ready  (dispatcher_ready),
        .instr0_fifo_rd_en (rd0),
        .instr0_fifo_data  (d0),
        .instr0_fifo_empty (e0),
        .instr1_fifo_rd_en (rd1),
        .instr1_fifo_data  (d1),
        .instr1_fifo_empty (e1),
        .instr_valid       (instr_valid),
        .instr_ready       (instr_ready),
        .instr_data        (instr_data),
        .iseq_done         (iseq_done),
        .instr_count       (instr_count),
        .order_err         (order_err)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    logic [31:0] f0[$], f1[$];       // FIFO contents (bench-owned model)
    logic [31:0] ld0[$], ld1[$];     // Iseq image written by the "receiver"
    logic [31:0] r0[$], r1[$];       // expected leftovers after the fetch
    logic [31:0] sb[$];              // expected output stream
    int          acc_cyc[$];
    int          exp_n;
    logic        exp_err = 1'b0;
    logic        pend0 = 1'b0, pend1 = 1'b0;
    int          cyc = 0;
    int          done_cnt = 0;
    int          done_cyc = 0;
    logic        hold_prev = 1'b0;
    logic [31:0] hold_data = '0;
    int          ready_mode = 0;
    int          pat_idx = 0;

    localparam logic [31:0] END_W = {END_ISEQ, 28'h0};

    function automatic void fifo_refresh();
        e0 = (f0.size() == 0);
        e1 = (f1.size() == 0);
        d0 = e0 ? 32'h0 : f0[0];
        d1 = e1 ? 32'h0 : f1[0];
    endfunction

    function automatic logic [31:0] rand_word();
        logic [31:0] w;
        w = $urandom;
        if (w[31:28] == END_ISEQ) w[31:28] = 4'h1;
        return w;
    endfunction

    // Reference: words leave in write order, alternating FIFO0/FIFO1, until an END word
    // (dropped) or until the FIFO whose turn it is has nothing left.
    task automatic model();
        logic [31:0] q0[$], q1[$];
        logic [31:0] w;
        bit          s;
        q0 = ld0; q1 = ld1; s = 0; exp_n = 0;
        for (int k = 0; k < 200; k++) begin
            if ((s ? q1.size() : q0.size()) == 0) begin
                if ((s ? q0.size() : q1.size()) != 0) exp_err = 1'b1;
                break;
            end
            if (s) w = q1.pop_front(); else w = q0.pop_front();
            s = !s;
            if (w[31:28] == END_ISEQ) break;
            sb.push_back(w);
            exp_n++;
        end
        r0 = q0; r1 = q1;
    endtask

    // FIFO pops take effect on the clock edge where rd_en was high.
    always @(posedge clk) begin
        #1;
        if (pend0 && f0.size() > 0) f0.delete(0);
        if (pend1 && f1.size() > 0) f1.delete(0);
        fifo_refresh();
    end

    initial begin
        forever begin
            @(posedge clk);
            #1;
            case (ready_mode)
                1:       instr_ready = 1'($urandom_range(0, 1));
                2:       instr_ready = !(pat_idx % 4 == 1 || pat_idx % 4 == 2);
                default: instr_ready = 1'b1;
            endcase
            pat_idx++;
        end
    end

    // Monitor: compares every accepted word against the scoreboard.
    always @(negedge clk) begin
        cyc++;
        pend0 = rd0;
        pend1 = rd1;
        if (rst) begin
            hold_prev = 1'b0;
        end else begin
            if (rd0) check("pop0_nonempty", 32'(e0), 32'd0);
            if (rd1) check("pop1_nonempty", 32'(e1), 32'd0);
            if (instr_valid && !instr_ready) check("no_pop_in_stall", {30'd0, rd1, rd0}, 32'd0);
            if (hold_prev) begin
                check("hold_valid", 32'(instr_valid), 32'd1);
                check("hold_data", instr_data, hold_data);
            end
            hold_prev = instr_valid && !instr_ready;
            hold_data = instr_data;
            if (instr_valid && instr_ready) begin
                if (sb.size() == 0) begin
                    check("unexpected_output", instr_data, 32'hxxxx_xxxx);
                end else begin
                    check("instr_data", instr_data, sb.pop_front());
                end
                acc_cyc.push_back(cyc);
            end
            if (iseq_done) begin
                done_cnt++;
                done_cyc = cyc;
            end
        end
    end

    task automatic apply_reset();
        @(posedge clk);
        #1 rst = 1'b1;
        f0.delete(); f1.delete(); sb.delete();
        fifo_refresh();
        exp_err = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("rst_order_err", 32'(order_err), 32'd0);
        check("rst_disp_ready", 32'(dispatcher_ready), 32'd1);
    endtask

    task automatic pulse_iseq();
        process_iseq = 1'b1;
        @(posedge clk);
        #1 process_iseq = 1'b0;
    endtask

    task automatic wait_done(input int start, input int bound);
        int n = 0;
        while (done_cnt == start && n < bound) begin
            @(negedge clk);
            n++;
        end
        check("iseq_done_seen", 32'(done_cnt != start), 32'd1);
    endtask

    task automatic run_iseq(input int mode, input bit dup_pulse, input bit chk_timing);
        int start;
        int last;
        ready_mode = mode;
        @(posedge clk);
        #1;
        check("disp_ready_idle", 32'(dispatcher_ready), 32'd1);
        f0 = ld0; f1 = ld1;
        fifo_refresh();
        model();
        acc_cyc.delete();
        start = done_cnt;
        pulse_iseq();
        check("disp_ready_drop", 32'(dispatcher_ready), 32'd0);
        if (dup_pulse) begin
            repeat (2) @(posedge clk);
            #1 pulse_iseq();
        end
        wait_done(start, 500);
        check("acc_count", acc_cyc.size(), exp_n);
        check("sb_drained", sb.size(), 32'd0);
        check("instr_count", 32'(instr_count), exp_n);
        check("order_err", 32'(order_err), 32'(exp_err));
        check("left0_size", f0.size(), r0.size());
        check("left1_size", f1.size(), r1.size());
        for (int i = 0; i < f0.size() && i < r0.size(); i++) check("left0_word", f0[i], r0[i]);
        for (int i = 0; i < f1.size() && i < r1.size(); i++) check("left1_word", f1[i], r1[i]);
        if (chk_timing && acc_cyc.size() > 0) begin
            last = acc_cyc.size() - 1;
            check("back_to_back", acc_cyc[last] - acc_cyc[0], last);
            check("done_latency", done_cyc - acc_cyc[last], 32'd1);
        end
        repeat (5) @(negedge clk);
        check("stays_idle", 32'(dispatcher_ready), 32'd1);
        check("single_done", done_cnt - start, 32'd1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, got timeout, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int bound;
        rst = 1'b1; process_iseq = 1'b0; instr_ready = 1'b1;
        fifo_refresh();
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_disp_ready", 32'(dispatcher_ready), 32'd1);
        check("reset_rd_en", {30'd0, rd1, rd0}, 32'd0);
        check("reset_valid", 32'(instr_valid), 32'd0);
        check("reset_data", instr_data, 32'd0);
        check("reset_done", 32'(iseq_done), 32'd0);
        check("reset_count", 32'(instr_count), 32'd0);
        check("reset_order_err", 32'(order_err), 32'd0);
        @(posedge clk);
        #1 rst = 1'b0;

        // Normal Iseq with END, full throughput.
        ld0 = '{32'h1000_00A0, 32'h1000_00A2, END_W};
        ld1 = '{32'h1000_00A1, 32'h1000_00A3};
        run_iseq(0, 0, 1);

        // Maintenance Iseq: no END, ends when FIFO1's turn finds it empty.
        ld0 = '{32'h2000_00B0, 32'h2000_00B2};
        ld1 = '{32'h2000_00B1};
        run_iseq(0, 0, 0);

        // Output stalls with ready pattern 1,0,0,1.
        ld0 = '{32'h3000_0000, 32'h3000_0002, 32'h3000_0004, END_W};
        ld1 = '{32'h3000_0001, 32'h3000_0003, 32'h3000_0005};
        run_iseq(2, 0, 0);

        // FIFO0 empty while FIFO1 holds a word at the first read.
        ld0.delete();
        ld1 = '{32'h4000_0001};
        run_iseq(0, 0, 0);
        apply_reset();

        // Extra pulse while fetching is ignored; the next Iseq restarts at FIFO0.
        ld0.delete(); ld1.delete();
        for (int k = 0; k < 10; k++) begin
            if (k % 2 == 0) ld0.push_back(rand_word()); else ld1.push_back(rand_word());
        end
        ld0.push_back(END_W);
        run_iseq(0, 1, 0);
        ld0 = '{32'h5000_0000, END_W};
        ld1 = '{32'h5000_0001};
        run_iseq(0, 0, 0);

        // Reset in the middle of FETCH.
        ld0.delete(); ld1.delete();
        for (int k = 0; k < 12; k++) begin
            if (k % 2 == 0) ld0.push_back(rand_word()); else ld1.push_back(rand_word());
        end
        ld0.push_back(END_W);
        ready_mode = 0;
        @(posedge clk);
        #1 f0 = ld0; f1 = ld1;
        fifo_refresh();
        model();
        acc_cyc.delete();
        pulse_iseq();
        bound = 0;
        while (acc_cyc.size() < 2 && bound < 50) begin
            @(negedge clk);
            bound++;
        end
        check("midrst_streaming", 32'(acc_cyc.size() >= 2), 32'd1);
        @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("midrst_disp_ready", 32'(dispatcher_ready), 32'd1);
        check("midrst_rd_en", {30'd0, rd1, rd0}, 32'd0);
        check("midrst_valid", 32'(instr_valid), 32'd0);
        check("midrst_count", 32'(instr_count), 32'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        f0.delete(); f1.delete(); sb.delete();
        fifo_refresh();
        exp_err = 1'b0;

        // Randomised Iseqs with random backpressure, END placement and stray words.
        for (int it = 0; it < 30; it++) begin
            ld0.delete(); ld1.delete();
            n = $urandom_range(0, 12);
            for (int k = 0; k < n; k++) begin
                if (k % 2 == 0) ld0.push_back(rand_word()); else ld1.push_back(rand_word());
            end
            if ($urandom_range(0, 1) == 1) begin
                if (n % 2 == 0) ld0.push_back(END_W); else ld1.push_back(END_W);
            end
            if ($urandom_range(0, 3) == 0) begin
                if ($urandom_range(0, 1) == 1) ld0.push_back(rand_word());
                else                           ld1.push_back(rand_word());
            end
            run_iseq(1, 0, 0);
            if (it % 6 == 5) apply_reset();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
